cordic_atan_feeder: RTL and testbench

// - Upstream stage of the CORDIC arctangent core. Buffers (x,y) samples arriving on a valid/ready stream
//   and pre-scales each by <<EXPAND_BIT.
// - Presents each sample to the core, held stable on the one cycle per 2**CYCLES-cycle frame when the core latches it.
// - Flags which frames carry real samples, so downstream can discard bubble results.

---
 rtl/cordic_pkg.sv | 38 +++
 rtl/cordic_feed_fifo.sv | 68 ++++++
 rtl/cordic_atan_feeder.sv | 141 ++++++++++++++
 tb/tb_cordic_atan_feeder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_pkg
//  Description : Shared types and helpers for the CORDIC arctangent feeder
//                and core. Holds the sample record and the frame-length and
//                saturation-limit helpers. It also holds the quadrant codes
//                that the core uses for pre-rotation.
//  Revision    : 1.0  initial release
// ============================================================================
package cordic_pkg;

  // Width of one input coordinate carried in sample_t.
  localparam int unsigned c_SAMPLE_W = 16;

  typedef struct packed {
    logic signed [c_SAMPLE_W-1:0] x;
    logic signed [c_SAMPLE_W-1:0] y;
  } sample_t;

  // Quadrant codes used by the core's pre-rotation stage.
  localparam logic [1:0] c_QUAD_I   = 2'd0;
  localparam logic [1:0] c_QUAD_II  = 2'd1;
  localparam logic [1:0] c_QUAD_III = 2'd2;
  localparam logic [1:0] c_QUAD_IV  = 2'd3;

  // Clocks per core frame.
  function automatic int unsigned frame_len(input int unsigned cycles);
    return 32'd1 << cycles;
  endfunction

  // Largest magnitude handed to the core. Two bits of headroom cover the
  // ~1.65 CORDIC gain and keep the negative limit negatable.
  function automatic longint sat_max(input int unsigned data_width);
    return (64'sd1 <<< (data_width - 2)) - 64'sd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cordic_feed_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_feed_fifo
//  Description : Synchronous FIFO of sample_t used to buffer the feeder input.
//                It does not push while full, even when a pop happens on the
//                same edge. clr flushes the FIFO and drops a push on the same
//                edge. A simultaneous push and pop leave the level unchanged.
//  Ports       : clk, rst_n (sync, active-low), i_clr (sync flush),
//                i_push/i_data (write), i_pop (read), o_head (current head),
//                o_full, o_empty, o_level (occupancy 0..DEPTH)
//  Revision    : 1.0  initial release
// ============================================================================
module cordic_feed_fifo
  import cordic_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_clr,
  input  logic                     i_push,
  input  sample_t                  i_data,
  input  logic                     i_pop,
  output sample_t                  o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int c_AW = $clog2(DEPTH);

  sample_t          r_mem [DEPTH];
  logic [c_AW:0]    r_wr_ptr;
  logic [c_AW:0]    r_rd_ptr;
  logic [c_AW:0]    w_level;
  logic             w_do_push;
  logic             w_do_pop;

  // Pointers carry one extra wrap bit, so their difference is the true level.
  assign w_level   = r_wr_ptr - r_rd_ptr;
  assign o_level   = w_level;
  assign o_full    = (w_level == (c_AW+1)'(DEPTH));
  assign o_empty   = (w_level == '0);
  assign o_head    = r_mem[r_rd_ptr[c_AW-1:0]];

  assign w_do_push = i_push && !o_full && !i_clr;
  assign w_do_pop  = i_pop  && !o_empty && !i_clr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[c_AW-1:0]] <= i_data;
  end

endmodule
`default_nettype wire

// File: rtl/cordic_atan_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_atan_feeder
//  Description : Upstream stage of the CORDIC arctangent core. Buffers (x,y)
//                samples and pops one per 2**CYCLES-clock frame, on the last
//                phase of the frame. Each popped sample is pre-scaled by
//                <<EXPAND_BIT. x_out/y_out stay stable while frame_cnt==0,
//                which is when the core latches them. cur_real marks the
//                frames that carry a real sample.
//  Config      : CORDIC_FEED_SAT_EN - when defined, the scaled values saturate
//                to +/-(2**(DATA_WIDTH-2)-1). Otherwise they are truncated.
//  Ports       : clk, rst_n (sync, active-low), clr (sync flush),
//                s_valid/s_ready/s_x/s_y (input stream),
//                x_out/y_out (scaled operands to core), frame_cnt (phase),
//                cur_real (frame holds a real sample), level (buffer count)
//  Revision    : 1.0  initial release
// ============================================================================
module cordic_atan_feeder
  import cordic_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IN_WIDTH   = 16,
  parameter int EXPAND_BIT = 16,
  parameter int CYCLES     = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [IN_WIDTH-1:0]           s_x,
  input  logic [IN_WIDTH-1:0]           s_y,
  output logic [DATA_WIDTH-1:0]         x_out,
  output logic [DATA_WIDTH-1:0]         y_out,
  output logic [CYCLES-1:0]             frame_cnt,
  output logic                          cur_real,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int unsigned     c_FRAME_LEN = frame_len(CYCLES);
  localparam logic [CYCLES-1:0] c_LAST    = CYCLES'(c_FRAME_LEN - 1);
  localparam int              c_WW        = DATA_WIDTH + EXPAND_BIT;

`ifdef CORDIC_FEED_SAT_EN
  localparam logic signed [c_WW-1:0] c_SAT_POS = c_WW'(sat_max(DATA_WIDTH));
  localparam logic signed [c_WW-1:0] c_SAT_NEG = -c_SAT_POS;
`endif

  // Sign-extend to the full product width, shift, then narrow.
  function automatic logic [DATA_WIDTH-1:0] scale_coord(
    input logic signed [IN_WIDTH-1:0] s
  );
    logic signed [c_WW-1:0] w;
    w = c_WW'(s);
    w = w <<< EXPAND_BIT;
`ifdef CORDIC_FEED_SAT_EN
    if (w > c_SAT_POS)      return c_SAT_POS[DATA_WIDTH-1:0];
    else if (w < c_SAT_NEG) return c_SAT_NEG[DATA_WIDTH-1:0];
    else                    return w[DATA_WIDTH-1:0];
`else
    return w[DATA_WIDTH-1:0];
`endif
  endfunction

  logic [CYCLES-1:0]     r_frame_cnt;
  logic [DATA_WIDTH-1:0] r_x_out;
  logic [DATA_WIDTH-1:0] r_y_out;
  logic                  r_pend_real;
  logic                  r_cur_real;

  sample_t               w_push_data;
  sample_t               w_head;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop_edge;
  logic                  w_frame_start;
  logic                  w_fifo_pop;
  logic [DATA_WIDTH-1:0] w_x_scaled;
  logic [DATA_WIDTH-1:0] w_y_scaled;

  assign w_push_data.x = s_x;
  assign w_push_data.y = s_y;
  assign w_pop_edge    = (r_frame_cnt == c_LAST);
  assign w_frame_start = (r_frame_cnt == '0);
  assign w_fifo_pop    = w_pop_edge;
  assign w_x_scaled    = scale_coord(w_head.x);
  assign w_y_scaled    = scale_coord(w_head.y);

  cordic_feed_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (clr),
    .i_push  (s_valid),
    .i_data  (w_push_data),
    .i_pop   (w_fifo_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
      r_x_out     <= '0;
      r_y_out     <= '0;
      r_pend_real <= 1'b0;
      r_cur_real  <= 1'b0;
    end else begin
      // The frame counter free-runs so it stays aligned with the core.
      r_frame_cnt <= r_frame_cnt + 1'b1;
      if (clr) begin
        r_pend_real <= 1'b0;
        r_cur_real  <= 1'b0;
      end else begin
        if (w_pop_edge) begin
          if (!w_empty) begin
            r_x_out     <= w_x_scaled;
            r_y_out     <= w_y_scaled;
            r_pend_real <= 1'b1;
          end else begin
            r_pend_real <= 1'b0;
          end
        end
        // Delay by one frame phase so the flag covers the core's result window.
        if (w_frame_start) r_cur_real <= r_pend_real;
      end
    end
  end

  assign s_ready   = !w_full;
  assign x_out     = r_x_out;
  assign y_out     = r_y_out;
  assign frame_cnt = r_frame_cnt;
  assign cur_real  = r_cur_real;

endmodule
`default_nettype wire

// File: tb/tb_cordic_atan_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cordic_atan_feeder
//  Description : Scoreboard bench for cordic_atan_feeder. The stimulus pushes
//                hand-computed scaled values into a queue. A monitor pops and
//                compares them on every frame flagged real.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cordic_atan_feeder;

  localparam int DW = 32;
  localparam int IW = 16;
  localparam int EB = 16;
  localparam int CY = 5;
  localparam int FD = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clr = 1'b0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [IW-1:0]     s_x = '0;
  logic [IW-1:0]     s_y = '0;
  logic [DW-1:0]     x_out;
  logic [DW-1:0]     y_out;
  logic [CY-1:0]     frame_cnt;
  logic              cur_real;
  logic [$clog2(FD):0] level;

  always #5 clk = ~clk;

  cordic_atan_feeder #(
    .DATA_WIDTH (DW),
    .IN_WIDTH   (IW),
    .EXPAND_BIT (EB),
    .CYCLES     (CY),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_x       (s_x),
    .s_y       (s_y),
    .x_out     (x_out),
    .y_out     (y_out),
    .frame_cnt (frame_cnt),
    .cur_real  (cur_real),
    .level     (level)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [63:0] exp_q[$];

`ifdef CORDIC_FEED_SAT_EN
  localparam logic [31:0] c_NEG_Y  = 32'hC000_0001;
  localparam logic [31:0] c_BIG_X  = 32'h3FFF_FFFF;
`else
  localparam logic [31:0] c_NEG_Y  = 32'h8000_0000;
  localparam logic [31:0] c_BIG_X  = 32'h7FFF_0000;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=0x%08h required=0x%08h", name, cyc, act, exp);
    end
  endtask

  // Advance to the middle (negedge) of the next cycle.
  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic goto(input int n);
    while (cyc < n) step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    s_valid = 1'b0;
    clr     = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic push_one(input logic [15:0] x, input logic [15:0] y,
                          input logic [31:0] ex, input logic [31:0] ey,
                          output int acc);
    acc     = -1;
    s_x     = x;
    s_y     = y;
    s_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      if (s_ready) begin
        exp_q.push_back({ex, ey});
        acc = cyc;
        step();
        break;
      end
      step();
    end
    s_valid = 1'b0;
    if (acc < 0) begin
      checks++;
      errors++;
      $display("FAIL push_timeout cycle=%0d actual=no_accept required=accept", cyc);
    end
  endtask

  // Monitor: the frame just flagged real must carry the next expected sample.
  always @(negedge clk) begin : mon
    logic [63:0] e;
    if (rst_n && frame_cnt == 5'd1 && cur_real) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mon_unexpected_real cycle=%0d actual=real required=bubble", cyc);
      end else begin
        e = exp_q.pop_front();
        check("mon_x", x_out, e[63:32]);
        check("mon_y", y_out, e[31:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;

    // ---------------- single sample / bubble ----------------
    do_reset();
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_x_out",     x_out, 32'd0);
    check("rst_y_out",     y_out, 32'd0);
    check("rst_cur_real",  32'(cur_real), 32'd0);
    check("rst_s_ready",   32'(s_ready), 32'd1);
    check("rst_level",     32'(level), 32'd0);
    goto(5);
    push_one(16'd3, 16'd4, 32'h0003_0000, 32'h0004_0000, acc);
    check("single_acc_cycle", 32'(acc), 32'd5);
    check("single_level", 32'(level), 32'd1);
    goto(31);
    check("single_x_before_pop", x_out, 32'd0);
    goto(32);
    check("single_x", x_out, 32'h0003_0000);
    check("single_y", y_out, 32'h0004_0000);
    check("single_real_32", 32'(cur_real), 32'd0);
    check("single_level_after_pop", 32'(level), 32'd0);
    goto(33);
    check("single_real_33", 32'(cur_real), 32'd1);
    goto(64);
    check("single_real_64", 32'(cur_real), 32'd1);
    check("wrap_frame_cnt", 32'(frame_cnt), 32'd0);
    goto(65);
    check("single_real_65", 32'(cur_real), 32'd0);
    goto(100);
    check("bubble_real", 32'(cur_real), 32'd0);
    check("bubble_x_hold", x_out, 32'h0003_0000);
    check("bubble_y_hold", y_out, 32'h0004_0000);
    check("single_queue_empty", 32'(exp_q.size()), 32'd0);

    // ---------------- fill ----------------
    do_reset();
    goto(2);
    push_one(16'd1,      16'd2,      32'h0001_0000, 32'h0002_0000, acc);
    push_one(16'hFFFD,   16'hFFFC,   32'hFFFD_0000, 32'hFFFC_0000, acc);
    push_one(16'd100,    16'hFF38,   32'h0064_0000, 32'hFF38_0000, acc);
    push_one(16'h1234,   16'h0567,   32'h1234_0000, 32'h0567_0000, acc);
    check("fill_acc4_cycle", 32'(acc), 32'd5);
    check("fill_level_full", 32'(level), 32'd4);
    check("fill_s_ready_full", 32'(s_ready), 32'd0);
    push_one(16'd7, 16'd8, 32'h0007_0000, 32'h0008_0000, acc);
    check("fill_acc5_cycle", 32'(acc), 32'd32);
    check("fill_level_33", 32'(level), 32'd4);
    goto(160);
    check("fill_x_last", x_out, 32'h0007_0000);
    check("fill_y_last", y_out, 32'h0008_0000);
    goto(170);
    check("fill_queue_empty", 32'(exp_q.size()), 32'd0);

    // ---------------- negative / saturation ----------------
    do_reset();
    goto(3);
    push_one(16'hFFFF, 16'h8000, 32'hFFFF_0000, c_NEG_Y, acc);
    push_one(16'h7FFF, 16'h0000, c_BIG_X, 32'h0000_0000, acc);
    goto(32);
    check("neg_x", x_out, 32'hFFFF_0000);
    check("neg_y", y_out, c_NEG_Y);
    goto(64);
    check("big_x", x_out, c_BIG_X);
    check("big_y", y_out, 32'd0);
    goto(100);
    check("neg_queue_empty", 32'(exp_q.size()), 32'd0);

    // ---------------- flush ----------------
    do_reset();
    goto(2);
    push_one(16'd11, 16'd12, 32'h000B_0000, 32'h000C_0000, acc);
    push_one(16'd13, 16'd14, 32'h000D_0000, 32'h000E_0000, acc);
    push_one(16'd15, 16'd16, 32'h000F_0000, 32'h0010_0000, acc);
    check("flush_level_pre", 32'(level), 32'd3);
    goto(20);
    clr     = 1'b1;
    s_valid = 1'b1;
    s_x     = 16'd9;
    s_y     = 16'd9;
    exp_q.delete();
    step();
    clr     = 1'b0;
    s_valid = 1'b0;
    check("flush_level_21", 32'(level), 32'd0);
    check("flush_real_21", 32'(cur_real), 32'd0);
    check("flush_s_ready", 32'(s_ready), 32'd1);
    goto(32);
    check("flush_bubble_x", x_out, 32'd0);
    goto(40);
    check("flush_real_40", 32'(cur_real), 32'd0);
    check("flush_queue_empty", 32'(exp_q.size()), 32'd0);

    // ---------------- reset mid-frame ----------------
    do_reset();
    goto(2);
    push_one(16'd5, 16'd6, 32'h0005_0000, 32'h0006_0000, acc);
    goto(40);
    check("midrst_real_before", 32'(cur_real), 32'd1);
    rst_n = 1'b0;
    exp_q.delete();
    step();
    rst_n = 1'b1;
    cyc   = 0;
    check("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("midrst_cur_real", 32'(cur_real), 32'd0);
    check("midrst_level", 32'(level), 32'd0);
    check("midrst_x", x_out, 32'd0);
    check("midrst_y", y_out, 32'd0);
    goto(1);
    push_one(16'hFFFE, 16'd10, 32'hFFFE_0000, 32'h000A_0000, acc);
    goto(31);
    check("midrst_x_31", x_out, 32'd0);
    goto(32);
    check("midrst_x_32", x_out, 32'hFFFE_0000);
    check("midrst_y_32", y_out, 32'h000A_0000);
    goto(40);
    check("midrst_real_after", 32'(cur_real), 32'd1);
    check("midrst_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
